// File: rtl/fm_copy_engine.sv
// fm_copy_engine: copies IFM buffer words to OFM buffer addresses under control of the
// feature-map address sequencer, realigning write strobes to the IFM read latency.
`ifndef FM_BUFFER_AW
`define FM_BUFFER_AW 12
`endif

module fm_copy_engine #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned IFM_AW = `FM_BUFFER_AW,
    parameter int unsigned OFM_AW = `FM_BUFFER_AW,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              q_copy_start,
    input  logic [CNT_W-1:0]  q_expected_cnt,
    input  logic              as_rd_vld,
    input  logic [IFM_AW-1:0] as_rd_addr,
    input  logic              as_wr_vld,
    input  logic [OFM_AW-1:0] as_wr_addr,
    input  logic              addr_seq_done,
    output logic              ifm_rd_en,
    output logic [IFM_AW-1:0] ifm_rd_addr,
    input  logic [DATA_W-1:0] ifm_rd_data,
    output logic              ofm_wr_en,
    output logic [OFM_AW-1:0] ofm_wr_addr,
    output logic [DATA_W-1:0] ofm_wr_data,
    output logic              copy_busy,
    output logic              copy_done,
    output logic              copy_err,
    output logic [CNT_W-1:0]  copy_wr_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic                w_run, w_rd_acc, w_start, w_done_entry, w_err_set;
    logic                w_dl_vld, w_dl_empty;
    logic [OFM_AW-1:0]   w_dl_addr;
    logic [2:0]          r_pend;
    logic [CNT_W-1:0]    r_exp, r_cnt, w_cnt_nxt;
    logic                r_err, r_we;
    logic [OFM_AW-1:0]   r_wa;
    logic [DATA_W-1:0]   r_wd;

    assign w_run       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_rd_acc    = as_rd_vld && w_run;
    assign w_start     = q_copy_start && (r_state == S_IDLE);
    assign ifm_rd_en   = w_rd_acc;
    assign ifm_rd_addr = w_rd_acc ? as_rd_addr : '0;

    // Write strobe already trails the read by one cycle, so RD_LAT-1 more stages align it with read data.
    generate
        if (RD_LAT <= 1) begin : g_nodl
            assign w_dl_vld   = as_wr_vld;
            assign w_dl_addr  = as_wr_addr;
            assign w_dl_empty = 1'b1;
        end else begin : g_dl
            localparam int unsigned N = RD_LAT - 1;
            logic [N-1:0]             r_dl_vld;
            logic [N-1:0][OFM_AW-1:0] r_dl_addr;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_dl_vld  <= '0;
                    r_dl_addr <= '0;
                end else begin
                    r_dl_vld[0]  <= as_wr_vld;
                    r_dl_addr[0] <= as_wr_addr;
                    for (int unsigned i = 1; i < N; i++) begin
                        r_dl_vld[i]  <= r_dl_vld[i-1];
                        r_dl_addr[i] <= r_dl_addr[i-1];
                    end
                end
            end
            assign w_dl_vld   = r_dl_vld[N-1];
            assign w_dl_addr  = r_dl_addr[N-1];
            assign w_dl_empty = ~|r_dl_vld;
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_done_entry = 1'b0;
        case (r_state)
            S_IDLE:  if (q_copy_start) w_state_nxt = S_RUN;
            S_RUN:   if (addr_seq_done) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if ((r_pend == '0) && w_dl_empty && !w_dl_vld && !as_wr_vld) begin
                    w_state_nxt  = S_DONE;
                    w_done_entry = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The last output write may retire on the same edge as DONE entry, so compare the next count.
    assign w_cnt_nxt = (r_we && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_err_set = (as_rd_vld && !w_run) ||
                       (as_wr_vld && (r_pend == '0)) ||
                       (w_done_entry && (w_cnt_nxt != r_exp));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_exp   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_pend <= '0;
                r_exp  <= q_expected_cnt;
                r_cnt  <= '0;
                r_err  <= 1'b0;
            end else begin
                r_cnt <= w_cnt_nxt;
                if (w_err_set) r_err <= 1'b1;
                if (w_rd_acc && !as_wr_vld) r_pend <= r_pend + 3'd1;
                else if (!w_rd_acc && as_wr_vld && (r_pend != '0)) r_pend <= r_pend - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we <= 1'b0;
            r_wa <= '0;
            r_wd <= '0;
        end else begin
            r_we <= w_dl_vld;
            if (w_dl_vld) begin
                r_wa <= w_dl_addr;
                r_wd <= ifm_rd_data;
            end
        end
    end

    assign ofm_wr_en   = r_we;
    assign ofm_wr_addr = r_wa;
    assign ofm_wr_data = r_wd;
    assign copy_busy   = (r_state != S_IDLE);
    assign copy_done   = (r_state == S_DONE);
    assign copy_err    = r_err;
    assign copy_wr_cnt = r_cnt;

endmodule

// File: tb/tb_fm_copy_engine.sv
// Bench for fm_copy_engine: RD_LAT=1 and RD_LAT=3 instances exercised in turn against
// an IFM memory model and a write scoreboard keyed on expected cycle, address and data.
module tb_fm_copy_engine;
    localparam int DW = 128;
    localparam int AW = 8;
    localparam int CW = 24;
    localparam logic [DW-1:0] NOREAD = 128'hDEAD;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [1:0]         start, rd_vld, wr_vld, seq_done;
    logic [1:0][CW-1:0] exp_in;
    logic [1:0][AW-1:0] rd_addr, wr_addr;
    logic [1:0][DW-1:0] ifm_d;
    wire  [1:0]         rd_en, we, busy, done, err;
    wire  [1:0][AW-1:0] ifm_a, ofm_a;
    wire  [1:0][DW-1:0] ofm_d;
    wire  [1:0][CW-1:0] wcnt;

    always #5 clk = ~clk;

    fm_copy_engine #(.DATA_W(DW), .IFM_AW(AW), .OFM_AW(AW), .RD_LAT(1), .CNT_W(CW)) u_lat1 (
        .clk(clk), .rstn(rstn), .q_copy_start(start[0]), .q_expected_cnt(exp_in[0]),
        .as_rd_vld(rd_vld[0]), .as_rd_addr(rd_addr[0]), .as_wr_vld(wr_vld[0]),
        .as_wr_addr(wr_addr[0]), .addr_seq_done(seq_done[0]), .ifm_rd_en(rd_en[0]),
        .ifm_rd_addr(ifm_a[0]), .ifm_rd_data(ifm_d[0]), .ofm_wr_en(we[0]),
        .ofm_wr_addr(ofm_a[0]), .ofm_wr_data(ofm_d[0]), .copy_busy(busy[0]),
        .copy_done(done[0]), .copy_err(err[0]), .copy_wr_cnt(wcnt[0]));

    fm_copy_engine #(.DATA_W(DW), .IFM_AW(AW), .OFM_AW(AW), .RD_LAT(3), .CNT_W(CW)) u_lat3 (
        .clk(clk), .rstn(rstn), .q_copy_start(start[1]), .q_expected_cnt(exp_in[1]),
        .as_rd_vld(rd_vld[1]), .as_rd_addr(rd_addr[1]), .as_wr_vld(wr_vld[1]),
        .as_wr_addr(wr_addr[1]), .addr_seq_done(seq_done[1]), .ifm_rd_en(rd_en[1]),
        .ifm_rd_addr(ifm_a[1]), .ifm_rd_data(ifm_d[1]), .ofm_wr_en(we[1]),
        .ofm_wr_addr(ofm_a[1]), .ofm_wr_data(ofm_d[1]), .copy_busy(busy[1]),
        .copy_done(done[1]), .copy_err(err[1]), .copy_wr_cnt(wcnt[1]));

    // IFM memory model: word = address + 100, returned RD_LAT cycles after the enable.
    logic               m0_en = 1'b0;
    logic [AW-1:0]      m0_a = '0;
    logic [2:0]         m1_en = '0;
    logic [2:0][AW-1:0] m1_a = '0;
    always @(posedge clk) begin
        m0_en <= rd_en[0];
        m0_a  <= ifm_a[0];
        m1_en <= {m1_en[1:0], rd_en[1]};
        m1_a  <= {m1_a[1:0], ifm_a[1]};
    end
    always_comb begin
        ifm_d[0] = m0_en    ? DW'(m0_a) + DW'(100)    : NOREAD;
        ifm_d[1] = m1_en[2] ? DW'(m1_a[2]) + DW'(100) : NOREAD;
    end

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } sb_t;

    typedef struct {
        int e;
        int n;
        int wb;
        int rb;
        bit stray;
        bit restart;
        bit xerr;
        int xcnt;
    } job_t;

    sb_t  sbq[$];
    job_t jobs[7];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   act = 0;
    int   n_done[2] = '{0, 0};
    bit   xerr;
    int   xcnt;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut=%0d cyc=%0d got=%0h want=%0h", nm, act, cyc, got, want);
        end
    endtask

    task automatic push(input int c, input int a, input logic [DW-1:0] d);
        sb_t e;
        e.cyc = c;
        e.a   = AW'(a);
        e.d   = d;
        sbq.push_back(e);
    endtask

    task automatic monitor();
        sb_t e;
        for (int k = 0; k < 2; k++) begin
            if (we[k]) begin
                chk("busy_on_wr", DW'(busy[k]), DW'(1));
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected_wr dut=%0d cyc=%0d got addr=%0h want none", k, cyc, ofm_a[k]);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_cycle", DW'(cyc), DW'(e.cyc));
                    chk("wr_addr", DW'(ofm_a[k]), DW'(e.a));
                    chk("wr_data", ofm_d[k], e.d);
                end
            end
            if (done[k]) begin
                n_done[k]++;
                chk("done_err", DW'(err[k]), DW'(xerr));
                chk("done_cnt", DW'(wcnt[k]), DW'(xcnt));
                chk("done_after_last_wr", DW'(sbq.size()), DW'(0));
                chk("done_busy", DW'(busy[k]), DW'(1));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic outputs_zero(input int k, input string tag);
        chk({tag, "_rd_en"}, DW'(rd_en[k]), DW'(0));
        chk({tag, "_rd_addr"}, DW'(ifm_a[k]), DW'(0));
        chk({tag, "_wr_en"}, DW'(we[k]), DW'(0));
        chk({tag, "_wr_addr"}, DW'(ofm_a[k]), DW'(0));
        chk({tag, "_wr_data"}, ofm_d[k], DW'(0));
        chk({tag, "_busy"}, DW'(busy[k]), DW'(0));
        chk({tag, "_done"}, DW'(done[k]), DW'(0));
        chk({tag, "_err"}, DW'(err[k]), DW'(0));
        chk({tag, "_cnt"}, DW'(wcnt[k]), DW'(0));
    endtask

    task automatic run_job(input job_t j);
        int k = act;
        int lat = (act == 0) ? 1 : 3;
        int d0 = n_done[act];
        xerr = j.xerr;
        xcnt = j.xcnt;
        start[k]  = 1'b1;
        exp_in[k] = CW'(j.e);
        tick();
        start[k] = 1'b0;
        chk("err_clr_on_start", DW'(err[k]), DW'(0));
        chk("busy_run", DW'(busy[k]), DW'(1));
        for (int i = 0; i <= j.n; i++) begin
            rd_vld[k]  = (i < j.n);
            rd_addr[k] = AW'(j.rb + i);
            wr_vld[k]  = (i > 0);
            wr_addr[k] = AW'(j.wb + i - 1);
            if (j.restart) begin
                start[k] = (i == 1);
                if (i == 1) exp_in[k] = CW'(9);
            end
            if (i > 0) push(cyc + lat, j.wb + i - 1, DW'(j.rb + i - 1) + DW'(100));
            tick();
        end
        rd_vld[k] = 1'b0;
        start[k]  = 1'b0;
        if (j.stray) begin
            wr_vld[k]  = 1'b1;
            wr_addr[k] = AW'(j.wb + j.n);
            push(cyc + lat, j.wb + j.n, NOREAD);
            tick();
        end
        wr_vld[k]   = 1'b0;
        seq_done[k] = 1'b1;
        tick();
        seq_done[k] = 1'b0;
        for (int w = 0; w < 40 && n_done[k] == d0; w++) tick();
        chk("done_pulses", DW'(n_done[k] - d0), DW'(1));
    endtask

    initial begin
        int d0;
        start = '0; rd_vld = '0; wr_vld = '0; seq_done = '0;
        exp_in = '0; rd_addr = '0; wr_addr = '0;
        //         e   n   wb  rb stray rst xerr xcnt
        jobs[0] = '{4,  4,  8,  0, 0, 0, 0, 4};
        jobs[1] = '{5,  4,  8,  0, 0, 0, 1, 4};
        jobs[2] = '{4,  4,  20, 4, 0, 0, 0, 4};
        jobs[3] = '{5,  4,  30, 8, 1, 0, 1, 5};
        jobs[4] = '{3,  3,  40, 16, 0, 1, 0, 3};
        jobs[5] = '{16, 16, 64, 32, 0, 0, 0, 16};
        jobs[6] = '{16, 16, 96, 64, 0, 0, 0, 16};

        repeat (2) tick();
        for (int k = 0; k < 2; k++) outputs_zero(k, "reset");
        rstn = 1'b1;
        tick();

        for (int a = 0; a < 2; a++) begin
            act = a;
            // Read strobe while idle: dropped, flagged as error.
            rd_vld[a]  = 1'b1;
            rd_addr[a] = AW'(5);
            #1;
            chk("idle_rd_en", DW'(rd_en[a]), DW'(0));
            chk("idle_rd_addr", DW'(ifm_a[a]), DW'(0));
            tick();
            rd_vld[a] = 1'b0;
            chk("idle_rd_err", DW'(err[a]), DW'(1));
            chk("idle_busy", DW'(busy[a]), DW'(0));

            foreach (jobs[j]) run_job(jobs[j]);

            // Asynchronous reset in the middle of a job aborts it without a done pulse.
            d0 = n_done[a];
            start[a]  = 1'b1;
            exp_in[a] = CW'(2);
            tick();
            start[a]   = 1'b0;
            rd_vld[a]  = 1'b1;
            rd_addr[a] = AW'(3);
            #1;
            chk("run_rd_en", DW'(rd_en[a]), DW'(1));
            chk("run_rd_addr", DW'(ifm_a[a]), DW'(3));
            tick();
            rd_vld[a] = 1'b0;
            #2;
            rstn = 1'b0;
            #1;
            outputs_zero(a, "abort");
            tick();
            rstn = 1'b1;
            repeat (6) tick();
            chk("abort_no_done", DW'(n_done[a] - d0), DW'(0));
            chk("abort_idle", DW'(busy[a]), DW'(0));
            chk("abort_sb_empty", DW'(sbq.size()), DW'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d got no finish want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fm_copy_engine.md
Name: fm_copy_engine

Overview:
- Data-moving responder for the feature-map address sequencer (upsample/route modes).
- Consumes the sequencer's read strobe/address and one-cycle-delayed write strobe/address.
- Drives the IFM buffer read port, realigns write addresses to the buffer's read latency, and writes the returned words into the OFM buffer.
- Tracks completion and word count; reports done/error to the top controller.

Parameters:
- DATA_W, 128, FM buffer word width (Tin lanes x 8 bit)
- IFM_AW, `FM_BUFFER_AW, IFM buffer address width
- OFM_AW, `FM_BUFFER_AW, OFM buffer address width
- RD_LAT, 1, IFM buffer read latency in cycles; legal range 1..4
- CNT_W, 24, word counter width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- q_copy_start  in  1  one-cycle start pulse from top
- q_expected_cnt  in  CNT_W  expected OFM writes for this job; sampled on accepted start
- as_rd_vld  in  1  sequencer read strobe
- as_rd_addr  in  IFM_AW  sequencer read address
- as_wr_vld  in  1  sequencer write strobe; nominally 1 cycle after the matching as_rd_vld
- as_wr_addr  in  OFM_AW  sequencer write address
- addr_seq_done  in  1  sequencer done pulse
- ifm_rd_en  out  1  IFM buffer read enable
- ifm_rd_addr  out  IFM_AW  IFM buffer read address
- ifm_rd_data  in  DATA_W  IFM read data; valid RD_LAT cycles after ifm_rd_en
- ofm_wr_en  out  1  OFM buffer write enable (registered)
- ofm_wr_addr  out  OFM_AW  OFM write address (registered)
- ofm_wr_data  out  DATA_W  OFM write data (registered)
- copy_busy  out  1  high in RUN/DRAIN/DONE
- copy_done  out  1  one-cycle completion pulse
- copy_err  out  1  sticky error; cleared on accepted start
- copy_wr_cnt  out  CNT_W  OFM writes issued this job

Behaviour:
- Reset: all outputs 0; FSM IDLE; counters, delay line and pending counter cleared. Asserting rstn mid-job aborts immediately; no copy_done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE->RUN on q_copy_start: latch q_expected_cnt; clear copy_wr_cnt, copy_err, pending.
  - q_copy_start outside IDLE is ignored and does not set error.
  - RUN->DRAIN on addr_seq_done.
  - DRAIN->DONE when pending==0, the delay line is empty and no ofm_wr_en is scheduled next cycle.
  - DONE: copy_done=1 for exactly one cycle, then IDLE.
- Read path is combinational passthrough:
  - ifm_rd_en = as_rd_vld and (state RUN or DRAIN); ifm_rd_addr = as_rd_addr when enabled, else 0.
  - as_rd_vld in IDLE/DONE is dropped and sets copy_err.
- Write alignment: for read issued at cycle t, as_wr_* arrives at t+1. It passes through an RD_LAT-1 stage delay line (vld+addr), so it reaches t+RD_LAT, coincident with ifm_rd_data.
  - At t+RD_LAT the output register captures vld, addr and ifm_rd_data.
  - ofm_wr_en/addr/data are high/valid at t+RD_LAT+1. End-to-end read-to-write latency = RD_LAT+1.
  - RD_LAT=1: delay line has zero stages.
  - ofm_wr_addr/data hold their last value when ofm_wr_en=0.
- Pending counter (3 bits): +1 on accepted read, -1 on as_wr_vld. Both in one cycle: unchanged.
  - as_wr_vld with pending==0 sets copy_err; that write is still forwarded.
- copy_wr_cnt: +1 per ofm_wr_en; saturates at all-ones.
- On DONE entry, copy_wr_cnt != latched expected sets copy_err. copy_err is valid on the copy_done cycle.
- Back-to-back jobs: a start in the cycle after copy_done is accepted.

Test Plan:
- RD_LAT=1, expected=4; rd at cycles 10..13 (addr 0..3), wr at 11..14 (addr 8,9,10,11), ifm_rd_data=addr+100 -> ofm_wr_en cycles 12..15, addr 8..11, data 100..103; done pulse after addr_seq_done, err=0, cnt=4.
- RD_LAT=3, same stimulus -> ofm_wr_en at cycles 14..17 with identical addr/data pairing; copy_done only after the last write; busy stays high through drain.
- expected=5 with 4 transfers -> copy_done with copy_err=1, copy_wr_cnt=4; next start clears copy_err to 0.
- as_wr_vld with no prior read, and as_rd_vld in IDLE -> copy_err=1; IDLE read produces no ifm_rd_en.
- Second q_copy_start during RUN -> ignored, latched expected unchanged. rstn pulsed mid-RUN -> all outputs 0, state IDLE, no copy_done.
- Two back-to-back 16-word route jobs (start the cycle after copy_done) -> 32 correctly paired writes, two done pulses, err=0.
